branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side branch predictor. It is the producing end of the branch decision; the branch-condition comparator in execute is the resolving end.
- Fetch gets a combinational taken/target prediction for the current PC.
- Execute sends back the resolved outcome (br_type, br_taken, target), which trains a direct-mapped BTB with 2-bit saturating counters.
- Raises a mispredict flag so the core can redirect fetch.

Parameters:
- ENTRIES, 64, number of BTB entries; power of 2, ≥2. IDX_W = log2(ENTRIES).
- PC_W, 32, PC/target width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- pred_pc  in  PC_W  fetch PC to look up
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  predicted taken
- pred_target  out  PC_W  next-PC prediction
- upd_valid  in  1  resolved control-flow instruction this cycle
- upd_pc  in  PC_W  PC of the resolved instruction
- upd_br_type  in  3  branch type, same encoding as the branch comparator
- upd_taken  in  1  resolved taken (comparator output)
- upd_target  in  PC_W  resolved target address
- upd_pred_taken  in  1  prediction that was made for this instruction
- upd_pred_target  in  PC_W  predicted next-PC made for this instruction
- mispredict  out  1  fetch redirect required

Behaviour:
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
- Entry state: valid (1), tag, target (PC_W), ctr (2).
- Reset: while rst_n=0, every entry has valid=0 and ctr=2'b01. Target and tag are don't-care. Reset asserted mid-operation takes effect immediately, overriding any update in flight.
- Lookup (combinational from registered state, 0-cycle latency):
  - pred_hit = valid[idx] & tag match.
  - pred_taken = pred_hit & ctr[1].
  - pred_target = stored target if pred_taken, else pred_pc+4 (mod 2^PC_W).
  - During reset: pred_hit=0, pred_taken=0, pred_target=pred_pc+4.
- Update (rising clk, only when upd_valid=1):
  - br_type 3'b011 (not a branch): no table change.
  - br_type 3'b010 (unconditional): install/overwrite entry with valid=1, tag, target=upd_target, ctr=2'b11.
  - Conditional types (000,001,100,101,110,111), hit:
    - taken: ctr saturating increment (11 stays 11); target=upd_target.
    - not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Conditional types, miss:
    - taken: allocate with valid=1, tag, target=upd_target, ctr=2'b10. Evicts any prior occupant.
    - not taken: no allocation.
- Resolved next-PC = upd_target if upd_taken, else upd_pc+4.
- mispredict (combinational) = upd_valid & (upd_pred_target != resolved next-PC). Forced 0 when upd_valid=0 or rst_n=0.
  - br_type 3'b011 with upd_taken=0 still compares against upd_pc+4.
- Simultaneous lookup and update of the same index: lookup returns pre-update state. The write is visible from the next cycle; no bypass.
- Aliasing: PCs differing only in tag share an index. An allocation overwrites the prior occupant; a non-matching tag is always a miss.
- Only upd_valid=1 writes; all other cycles hold state.

Optional Feature:
- Macro BRANCH_PREDICTOR_STATS_EN.
- Defined:
  - Adds outputs stat_branches (32) and stat_mispredicts (32).
  - stat_branches increments on each upd_valid with br_type != 3'b011.
  - stat_mispredicts increments on each cycle mispredict=1.
  - Both wrap at 2^32 and reset to 0 on rst_n=0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-run after training, release, set pred_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104; mispredict=0 while rst_n=0.
- Allocation: update pc=0x100, type 000, taken, target=0x40, upd_pred_target=0x104 -> mispredict=1 that cycle. Next cycle lookup 0x100 -> hit=1, taken=1 (ctr=10), target=0x40.
- Saturation and hysteresis: after allocation, 3 taken updates keep ctr=11. Then 1 not-taken -> taken=1 (ctr=10). Second not-taken -> taken=0 (ctr=01), pred_target=0x104. Two more not-taken -> ctr=00, holds at 00.
- Non-branch and unconditional: type 011 at 0x200 -> no allocation, hit=0. Type 010 at 0x300, target 0x80 -> next cycle hit=1, taken=1, target=0x80. Not-taken miss at 0x400 -> no allocation.
- Aliasing and same-cycle access: with ENTRIES=64, train 0x100, then allocate 0x1100 (same index) -> lookup 0x100 misses. Lookup and update 0x500 in the same cycle -> lookup shows old state; the next cycle shows the new state.
- Stats (macro defined): 5 branch updates including 2 mispredicts, plus one type-011 update -> stat_branches=5, stat_mispredicts=2; both return to 0 after reset.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating counters,
// combinational lookup and mispredict detection. Optional counters: BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pred_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [2:0]      upd_br_type,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_target,
  output logic            mispredict
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  localparam logic [2:0] BR_NONE   = 3'b011;
  localparam logic [2:0] BR_UNCOND = 3'b010;

  logic             valid_reg  [ENTRIES];
  logic [1:0]       ctr_reg    [ENTRIES];
  logic [TAG_W-1:0] tag_reg    [ENTRIES];
  logic [PC_W-1:0]  target_reg [ENTRIES];

  logic [IDX_W-1:0] pred_idx, upd_idx;
  logic [TAG_W-1:0] pred_tag, upd_tag;
  logic             upd_hit;
  logic             wr_en;
  logic [1:0]       wr_ctr;
  logic [PC_W-1:0]  wr_target;
  logic [PC_W-1:0]  resolved_npc;
  logic             unused_pred_taken;

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign pred_tag = pred_pc[PC_W-1:IDX_W+2];
  assign upd_idx  = upd_pc[IDX_W+1:2];
  assign upd_tag  = upd_pc[PC_W-1:IDX_W+2];

  // The predicted direction travels with the target; only the target is compared.
  assign unused_pred_taken = upd_pred_taken;

  always_comb begin
    pred_hit    = rst_n & valid_reg[pred_idx] & (tag_reg[pred_idx] == pred_tag);
    pred_taken  = pred_hit & ctr_reg[pred_idx][1];
    pred_target = pred_taken ? target_reg[pred_idx] : pred_pc + PC_W'(4);
  end

  assign upd_hit = valid_reg[upd_idx] & (tag_reg[upd_idx] == upd_tag);

  always_comb begin
    wr_en     = 1'b0;
    wr_ctr    = ctr_reg[upd_idx];
    wr_target = target_reg[upd_idx];
    if (upd_valid) begin
      if (upd_br_type == BR_UNCOND) begin
        wr_en     = 1'b1;
        wr_ctr    = 2'b11;
        wr_target = upd_target;
      end else if (upd_br_type != BR_NONE) begin
        if (upd_hit) begin
          wr_en = 1'b1;
          if (upd_taken) begin
            wr_ctr    = (ctr_reg[upd_idx] == 2'b11) ? 2'b11 : ctr_reg[upd_idx] + 2'b01;
            wr_target = upd_target;
          end else begin
            wr_ctr    = (ctr_reg[upd_idx] == 2'b00) ? 2'b00 : ctr_reg[upd_idx] - 2'b01;
          end
        end else if (upd_taken) begin
          // Taken miss evicts whatever occupied the slot.
          wr_en     = 1'b1;
          wr_ctr    = 2'b10;
          wr_target = upd_target;
        end
      end
    end
  end

  assign resolved_npc = upd_taken ? upd_target : upd_pc + PC_W'(4);
  assign mispredict   = rst_n & upd_valid & (upd_pred_target != resolved_npc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i] <= 1'b0;
        ctr_reg[i]   <= 2'b01;
      end
    end else if (wr_en) begin
      valid_reg[upd_idx] <= 1'b1;
      ctr_reg[upd_idx]   <= wr_ctr;
    end
  end

  // Tag and target need no reset: they are only observed behind valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_reg[upd_idx]    <= upd_tag;
      target_reg[upd_idx] <= wr_target;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_branches_reg, stat_mispredicts_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_reg    <= 32'd0;
      stat_mispredicts_reg <= 32'd0;
    end else begin
      if (upd_valid && (upd_br_type != BR_NONE))
        stat_branches_reg <= stat_branches_reg + 32'd1;
      if (mispredict)
        stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_reg;
  assign stat_mispredicts = stat_mispredicts_reg;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: table-driven steps, expected lookup and
// mispredict values queued at drive time and compared on the following falling edge.
module tb_branch_predictor;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk;
  logic        rst_n;
  logic [31:0] pred_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [2:0]  upd_br_type;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int checks = 0;
  int errors = 0;

  // rst, uv, upd_pc, type, taken, target, pred_target, lookup_pc | exp hit, taken, target, mispredict
  typedef struct {
    logic        rst;
    logic        uv;
    logic [31:0] upc;
    logic [2:0]  typ;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] ppt;
    logic [31:0] lpc;
    logic        hit;
    logic        taken;
    logic [31:0] ptgt;
    logic        mis;
  } step_t;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  branch_predictor #(.ENTRIES(64), .PC_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pred_pc         (pred_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_br_type     (upd_br_type),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict)
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic apply(input step_t s);
    exp_t e;
    rst_n           = s.rst;
    upd_valid       = s.uv;
    upd_pc          = s.upc;
    upd_br_type     = s.typ;
    upd_taken       = s.tk;
    upd_target      = s.tgt;
    upd_pred_taken  = s.tk;
    upd_pred_target = s.ppt;
    pred_pc         = s.lpc;
    e.hit   = s.hit;
    e.taken = s.taken;
    e.tgt   = s.ptgt;
    e.mis   = s.mis;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    step_t tbl [3] = '{
      '{L,H,32'h100,3'b000,H,32'h40,32'h999,32'h100, L,L,32'h104,L},
      '{L,H,32'h100,3'b000,H,32'h40,32'h999,32'h100, L,L,32'h104,L},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h100,      L,L,32'h104,L}
    };
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      $display("reset[%0d] pc=%h hit=%b taken=%b tgt=%h mis=%b", i, pred_pc, pred_hit, pred_taken, pred_target, mispredict);
      checks += 4;
      if (pred_hit !== e.hit) begin errors++; $display("FAIL reset[%0d] pred_hit got %b exp %b", i, pred_hit, e.hit); end
      if (pred_taken !== e.taken) begin errors++; $display("FAIL reset[%0d] pred_taken got %b exp %b", i, pred_taken, e.taken); end
      if (pred_target !== e.tgt) begin errors++; $display("FAIL reset[%0d] pred_target got %h exp %h", i, pred_target, e.tgt); end
      if (mispredict !== e.mis) begin errors++; $display("FAIL reset[%0d] mispredict got %b exp %b", i, mispredict, e.mis); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alloc();
    step_t tbl [2] = '{
      '{H,H,32'h100,3'b000,H,32'h40,32'h104,32'h100, L,L,32'h104,H},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h100,      H,H,32'h40,L}
    };
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      $display("alloc[%0d] pc=%h hit=%b taken=%b tgt=%h mis=%b", i, pred_pc, pred_hit, pred_taken, pred_target, mispredict);
      checks += 4;
      if (pred_hit !== e.hit) begin errors++; $display("FAIL alloc[%0d] pred_hit got %b exp %b", i, pred_hit, e.hit); end
      if (pred_taken !== e.taken) begin errors++; $display("FAIL alloc[%0d] pred_taken got %b exp %b", i, pred_taken, e.taken); end
      if (pred_target !== e.tgt) begin errors++; $display("FAIL alloc[%0d] pred_target got %h exp %h", i, pred_target, e.tgt); end
      if (mispredict !== e.mis) begin errors++; $display("FAIL alloc[%0d] mispredict got %b exp %b", i, mispredict, e.mis); end
      @(posedge clk); #1;
    end
  endtask

  // Entry 0x100 starts at ctr=10; lookups show the counter before each update lands.
  task automatic test_saturation();
    step_t tbl [9] = '{
      '{H,H,32'h100,3'b000,H,32'h40,32'h40,32'h100,  H,H,32'h40,L},
      '{H,H,32'h100,3'b000,H,32'h40,32'h40,32'h100,  H,H,32'h40,L},
      '{H,H,32'h100,3'b000,H,32'h40,32'h40,32'h100,  H,H,32'h40,L},
      '{H,H,32'h100,3'b000,L,32'h0,32'h40,32'h100,   H,H,32'h40,H},
      '{H,H,32'h100,3'b000,L,32'h0,32'h40,32'h100,   H,H,32'h40,H},
      '{H,H,32'h100,3'b000,L,32'h0,32'h104,32'h100,  H,L,32'h104,L},
      '{H,H,32'h100,3'b000,L,32'h0,32'h104,32'h100,  H,L,32'h104,L},
      '{H,H,32'h100,3'b000,H,32'h40,32'h104,32'h100, H,L,32'h104,H},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h100,      H,L,32'h104,L}
    };
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      $display("sat[%0d] pc=%h hit=%b taken=%b tgt=%h mis=%b", i, pred_pc, pred_hit, pred_taken, pred_target, mispredict);
      checks += 4;
      if (pred_hit !== e.hit) begin errors++; $display("FAIL sat[%0d] pred_hit got %b exp %b", i, pred_hit, e.hit); end
      if (pred_taken !== e.taken) begin errors++; $display("FAIL sat[%0d] pred_taken got %b exp %b", i, pred_taken, e.taken); end
      if (pred_target !== e.tgt) begin errors++; $display("FAIL sat[%0d] pred_target got %h exp %h", i, pred_target, e.tgt); end
      if (mispredict !== e.mis) begin errors++; $display("FAIL sat[%0d] mispredict got %b exp %b", i, mispredict, e.mis); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_nonbranch_uncond();
    step_t tbl [8] = '{
      '{H,H,32'h200,3'b011,L,32'h0,32'h204,32'h200,  L,L,32'h204,L},
      '{H,H,32'h200,3'b011,L,32'h0,32'h208,32'h200,  L,L,32'h204,H},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h200,      L,L,32'h204,L},
      '{H,H,32'h300,3'b010,H,32'h80,32'h304,32'h300, L,L,32'h304,H},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h300,      H,H,32'h80,L},
      '{H,H,32'h400,3'b001,L,32'h0,32'h404,32'h400,  L,L,32'h404,L},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h400,      L,L,32'h404,L},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h300,      H,H,32'h80,L}
    };
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      $display("nbu[%0d] pc=%h hit=%b taken=%b tgt=%h mis=%b", i, pred_pc, pred_hit, pred_taken, pred_target, mispredict);
      checks += 4;
      if (pred_hit !== e.hit) begin errors++; $display("FAIL nbu[%0d] pred_hit got %b exp %b", i, pred_hit, e.hit); end
      if (pred_taken !== e.taken) begin errors++; $display("FAIL nbu[%0d] pred_taken got %b exp %b", i, pred_taken, e.taken); end
      if (pred_target !== e.tgt) begin errors++; $display("FAIL nbu[%0d] pred_target got %h exp %h", i, pred_target, e.tgt); end
      if (mispredict !== e.mis) begin errors++; $display("FAIL nbu[%0d] mispredict got %b exp %b", i, mispredict, e.mis); end
      @(posedge clk); #1;
    end
  endtask

  // 0x100, 0x300, 0x1100 and 0x500 all map to index 0 with 64 entries.
  task automatic test_alias();
    step_t tbl [7] = '{
      '{H,H,32'h100,3'b000,H,32'h40,32'h104,32'h300,   H,H,32'h80,H},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h300,        L,L,32'h304,L},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h100,        H,H,32'h40,L},
      '{H,H,32'h1100,3'b100,H,32'h60,32'h1104,32'h1100,L,L,32'h1104,H},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h100,        L,L,32'h104,L},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h1100,       H,H,32'h60,L},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h104,        L,L,32'h108,L}
    };
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      $display("alias[%0d] pc=%h hit=%b taken=%b tgt=%h mis=%b", i, pred_pc, pred_hit, pred_taken, pred_target, mispredict);
      checks += 4;
      if (pred_hit !== e.hit) begin errors++; $display("FAIL alias[%0d] pred_hit got %b exp %b", i, pred_hit, e.hit); end
      if (pred_taken !== e.taken) begin errors++; $display("FAIL alias[%0d] pred_taken got %b exp %b", i, pred_taken, e.taken); end
      if (pred_target !== e.tgt) begin errors++; $display("FAIL alias[%0d] pred_target got %h exp %h", i, pred_target, e.tgt); end
      if (mispredict !== e.mis) begin errors++; $display("FAIL alias[%0d] mispredict got %b exp %b", i, mispredict, e.mis); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_same_cycle();
    step_t tbl [5] = '{
      '{H,H,32'h500,3'b010,H,32'ha0,32'h504,32'h500, L,L,32'h504,H},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h500,      H,H,32'ha0,L},
      '{H,H,32'h500,3'b000,L,32'h0,32'ha0,32'h500,   H,H,32'ha0,H},
      '{H,H,32'h500,3'b000,H,32'hc0,32'ha0,32'h500,  H,H,32'ha0,H},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h503,      H,H,32'hc0,L}
    };
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      $display("same[%0d] pc=%h hit=%b taken=%b tgt=%h mis=%b", i, pred_pc, pred_hit, pred_taken, pred_target, mispredict);
      checks += 4;
      if (pred_hit !== e.hit) begin errors++; $display("FAIL same[%0d] pred_hit got %b exp %b", i, pred_hit, e.hit); end
      if (pred_taken !== e.taken) begin errors++; $display("FAIL same[%0d] pred_taken got %b exp %b", i, pred_taken, e.taken); end
      if (pred_target !== e.tgt) begin errors++; $display("FAIL same[%0d] pred_target got %h exp %h", i, pred_target, e.tgt); end
      if (mispredict !== e.mis) begin errors++; $display("FAIL same[%0d] mispredict got %b exp %b", i, mispredict, e.mis); end
      @(posedge clk); #1;
    end
  endtask

  // Reset lands while a mispredicting update is being driven; the update must be lost.
  task automatic test_reset_midrun();
    step_t tbl [3] = '{
      '{L,H,32'h500,3'b000,H,32'he0,32'ha0,32'h500, L,L,32'h504,L},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h100,     L,L,32'h104,L},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h500,     L,L,32'h504,L}
    };
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      $display("rstmid[%0d] pc=%h hit=%b taken=%b tgt=%h mis=%b", i, pred_pc, pred_hit, pred_taken, pred_target, mispredict);
      checks += 4;
      if (pred_hit !== e.hit) begin errors++; $display("FAIL rstmid[%0d] pred_hit got %b exp %b", i, pred_hit, e.hit); end
      if (pred_taken !== e.taken) begin errors++; $display("FAIL rstmid[%0d] pred_taken got %b exp %b", i, pred_taken, e.taken); end
      if (pred_target !== e.tgt) begin errors++; $display("FAIL rstmid[%0d] pred_target got %h exp %h", i, pred_target, e.tgt); end
      if (mispredict !== e.mis) begin errors++; $display("FAIL rstmid[%0d] mispredict got %b exp %b", i, mispredict, e.mis); end
      @(posedge clk); #1;
    end
  endtask

`ifdef BRANCH_PREDICTOR_STATS_EN
  task automatic test_stats();
    step_t tbl [7] = '{
      '{H,H,32'h100,3'b000,H,32'h40,32'h104,32'h800, L,L,32'h804,H},
      '{H,H,32'h100,3'b000,H,32'h40,32'h40,32'h800,  L,L,32'h804,L},
      '{H,H,32'h100,3'b000,L,32'h0,32'h104,32'h800,  L,L,32'h804,L},
      '{H,H,32'h100,3'b000,H,32'h40,32'h104,32'h800, L,L,32'h804,H},
      '{H,H,32'h300,3'b010,H,32'h80,32'h80,32'h800,  L,L,32'h804,L},
      '{H,H,32'h200,3'b011,L,32'h0,32'h204,32'h800,  L,L,32'h804,L},
      '{H,L,32'h0,3'b011,L,32'h0,32'h0,32'h800,      L,L,32'h804,L}
    };
    exp_t e;
    checks += 2;
    if (stat_branches !== 32'd0) begin errors++; $display("FAIL stats_start branches got %0d exp 0", stat_branches); end
    if (stat_mispredicts !== 32'd0) begin errors++; $display("FAIL stats_start mispredicts got %0d exp 0", stat_mispredicts); end
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      $display("stats[%0d] pc=%h hit=%b tgt=%h mis=%b br=%0d mp=%0d", i, pred_pc, pred_hit, pred_target, mispredict, stat_branches, stat_mispredicts);
      checks += 2;
      if (pred_hit !== e.hit) begin errors++; $display("FAIL stats[%0d] pred_hit got %b exp %b", i, pred_hit, e.hit); end
      if (mispredict !== e.mis) begin errors++; $display("FAIL stats[%0d] mispredict got %b exp %b", i, mispredict, e.mis); end
      @(posedge clk); #1;
    end
    checks += 2;
    if (stat_branches !== 32'd5) begin errors++; $display("FAIL stats_count branches got %0d exp 5", stat_branches); end
    if (stat_mispredicts !== 32'd2) begin errors++; $display("FAIL stats_count mispredicts got %0d exp 2", stat_mispredicts); end
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (stat_branches !== 32'd0) begin errors++; $display("FAIL stats_reset branches got %0d exp 0", stat_branches); end
    if (stat_mispredicts !== 32'd0) begin errors++; $display("FAIL stats_reset mispredicts got %0d exp 0", stat_mispredicts); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    rst_n           = 1'b0;
    pred_pc         = 32'h0;
    upd_valid       = 1'b0;
    upd_pc          = 32'h0;
    upd_br_type     = 3'b011;
    upd_taken       = 1'b0;
    upd_target      = 32'h0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = 32'h0;

    test_reset();
    test_alloc();
    test_saturation();
    test_nonbranch_uncond();
    test_alias();
    test_same_cycle();
    test_reset_midrun();
`ifdef BRANCH_PREDICTOR_STATS_EN
    test_stats();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
